// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register that sits directly in front of the ALU. It takes a
// decoded instruction from the decode stage under a valid/ready handshake. It
// resolves both operands through EX/WB forwarding and selects the immediate
// for operand B. It then registers the operands, the ALU operation code and
// the writeback controls for the ALU.
//
// Load-use hazards hold the instruction in decode until the load data exists.
// Downstream back-pressure freezes the stage. A flush discards the stage
// contents. A saturating counter records every cycle lost to a load-use stall.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid / id_ready        decode -> stage handshake
//   rs1_addr, rs2_addr,        source / destination register indices
//   rd_addr
//   rs1_data, rs2_data         register file read data
//   imm, use_imm               sign-extended immediate and operand B select
//   alu_ctrl_in                ALU operation code, passed through untouched
//   reg_write_in               instruction writes rd
//   ex_fwd_valid/rd/data       result currently in EX/MEM
//   wb_fwd_valid/rd/data       result being written back
//   ld_pending, ld_rd          load in EX whose data is not available yet
//   flush                      discard stage contents (redirect)
//   ex_ready                   ALU/EX accepts this cycle
//   ex_valid                   outputs hold a valid instruction
//   src_a, src_b               registered ALU operands
//   alu_control                registered ALU operation code
//   ex_rd, ex_reg_write        registered writeback controls
//   stall_cnt                  saturating load-use stall cycle counter
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  // Decode side
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_ctrl_in,
  input  logic              reg_write_in,

  // Forwarding sources
  input  logic              ex_fwd_valid,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,

  // Hazard / control
  input  logic              ld_pending,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic              flush,
  input  logic              ex_ready,

  // ALU side
  output logic              ex_valid,
  output logic [XLEN-1:0]   src_a,
  output logic [XLEN-1:0]   src_b,
  output logic [2:0]        alu_control,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Forward match qualifiers. x0 is hard-wired zero, so a producer that names
  // x0 as its destination never overrides the register file value.
  // ---------------------------------------------------------------------------
  logic ex_fwd_live;
  logic wb_fwd_live;

  assign ex_fwd_live = ex_fwd_valid && (ex_fwd_rd != ZERO_REG);
  assign wb_fwd_live = wb_fwd_valid && (wb_fwd_rd != ZERO_REG);

  // ---------------------------------------------------------------------------
  // Operand resolution. EX holds the younger result, so it has priority over
  // WB. WB in turn has priority over the register file.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_reg;
  logic [XLEN-1:0] op_b;

  always_comb begin
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned, which would infer a latch.
    op_a = rs1_data;
    if (ex_fwd_live && (ex_fwd_rd == rs1_addr)) begin
      op_a = ex_fwd_data;
    end else if (wb_fwd_live && (wb_fwd_rd == rs1_addr)) begin
      op_a = wb_fwd_data;
    end
  end

  always_comb begin
    op_b_reg = rs2_data;
    if (ex_fwd_live && (ex_fwd_rd == rs2_addr)) begin
      op_b_reg = ex_fwd_data;
    end else if (wb_fwd_live && (wb_fwd_rd == rs2_addr)) begin
      op_b_reg = wb_fwd_data;
    end
  end

  // The immediate wins outright. Any rs2 forwarding is irrelevant then.
  assign op_b = use_imm ? imm : op_b_reg;

  // ---------------------------------------------------------------------------
  // Load-use hazard. rs2 only matters when operand B actually reads it.
  // ---------------------------------------------------------------------------
  logic hazard;

  assign hazard = ld_pending && (ld_rd != ZERO_REG) &&
                  ((ld_rd == rs1_addr) || (!use_imm && (ld_rd == rs2_addr)));

  // ---------------------------------------------------------------------------
  // Handshake. The stage has room when it is empty or when its current
  // occupant leaves this cycle. ready must never depend on id_valid.
  // ---------------------------------------------------------------------------
  logic accept;

  assign id_ready = !hazard && (!ex_valid || ex_ready);
  assign accept   = id_valid && id_ready;

  // ---------------------------------------------------------------------------
  // Valid bit. flush beats accept. An instruction handed over in the flush
  // cycle is consumed from decode but never becomes visible to the ALU.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers. These load only on accept, so they hold their last
  // values while draining, stalled or back-pressured. They may load during a
  // flush. That is harmless because ex_valid stays low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a        <= '0;
      src_b        <= '0;
      alu_control  <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
    end else if (accept) begin
      src_a        <= op_a;
      src_b        <= op_b;
      alu_control  <= alu_ctrl_in;
      ex_rd        <= rd_addr;
      ex_reg_write <= reg_write_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter. It counts every cycle in which decode is blocked by a
  // load-use hazard, and it also counts during a flush. It sticks at
  // all-ones rather than wrapping, so a long run never reads as a short one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid && hazard && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed testbench for alu_operand_stage. Each step drives one vector, and
// every expected value is written out by hand next to its check.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic              use_imm;
  logic [2:0]        alu_ctrl_in;
  logic              reg_write_in;
  logic              ex_fwd_valid;
  logic [REG_AW-1:0] ex_fwd_rd;
  logic [XLEN-1:0]   ex_fwd_data;
  logic              wb_fwd_valid;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;
  logic              ld_pending;
  logic [REG_AW-1:0] ld_rd;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [2:0]        alu_control;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  alu_operand_stage #(
    .XLEN  (XLEN),
    .REG_AW(REG_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .use_imm     (use_imm),
    .alu_ctrl_in (alu_ctrl_in),
    .reg_write_in(reg_write_in),
    .ex_fwd_valid(ex_fwd_valid),
    .ex_fwd_rd   (ex_fwd_rd),
    .ex_fwd_data (ex_fwd_data),
    .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_data (wb_fwd_data),
    .ld_pending  (ld_pending),
    .ld_rd       (ld_rd),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .ex_rd       (ex_rd),
    .ex_reg_write(ex_reg_write),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge. Registered outputs are
  // sampled here, well away from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction that reads rs1 and the immediate.
  task automatic instr(input logic [REG_AW-1:0] a1, input logic [XLEN-1:0] d1,
                       input logic [XLEN-1:0] im, input logic [2:0] ctrl,
                       input logic [REG_AW-1:0] rd);
    id_valid     = 1'b1;
    rs1_addr     = a1;
    rs1_data     = d1;
    use_imm      = 1'b1;
    imm          = im;
    alu_ctrl_in  = ctrl;
    rd_addr      = rd;
    reg_write_in = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0;
    alu_ctrl_in = '0; reg_write_in = 1'b0;
    ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    ld_pending = 1'b0; ld_rd = '0; flush = 1'b0; ex_ready = 1'b1;

    // ---------------- reset state ----------------
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- basic accept with immediate ----------------
    instr(5'd3, 32'h10, 32'hFFFF_FFFC, 3'b010, 5'd4);
    #1;
    check("acc_id_ready", id_ready, 1);
    tick();
    check("acc_ex_valid", ex_valid, 1);
    check("acc_src_a", src_a, 32'h10);
    check("acc_src_b", src_b, 32'hFFFF_FFFC);
    check("acc_alu_ctrl", alu_control, 3'b010);
    check("acc_ex_rd", ex_rd, 5'd4);
    check("acc_reg_write", ex_reg_write, 1);
    id_valid = 1'b0;
    tick();
    check("drain_ex_valid", ex_valid, 0);
    check("drain_src_a_hold", src_a, 32'h10);

    // ---------------- forwarding ----------------
    id_valid = 1'b1; use_imm = 1'b0; alu_ctrl_in = 3'b111; rd_addr = 5'd2;
    rs1_addr = 5'd5; rs1_data = 32'h1;
    rs2_addr = 5'd5; rs2_data = 32'h2;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'hAAAA;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'hBBBB;
    tick();
    check("fwd_ex_src_a", src_a, 32'hAAAA);
    check("fwd_ex_src_b", src_b, 32'hAAAA);
    check("fwd_undef_ctrl", alu_control, 3'b111);
    ex_fwd_valid = 1'b0;
    tick();
    check("fwd_wb_src_a", src_a, 32'hBBBB);
    check("fwd_wb_src_b", src_b, 32'hBBBB);
    // x0 never forwards, even when both producers name it.
    rs1_addr = 5'd0; rs1_data = 32'h1234;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0;
    wb_fwd_rd = 5'd0;
    tick();
    check("fwd_x0_src_a", src_a, 32'h1234);
    // The immediate wins over a matching rs2 forward.
    rs2_addr = 5'd6; ex_fwd_rd = 5'd6; ex_fwd_data = 32'hCCCC;
    use_imm = 1'b1; imm = 32'h55;
    tick();
    check("imm_over_fwd", src_b, 32'h55);
    check("imm_ex_valid", ex_valid, 1);
    ex_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;

    // ---------------- load-use hazard on rs2 ----------------
    rs1_addr = 5'd1; rs1_data = 32'h99; rs2_addr = 5'd7; use_imm = 1'b0;
    ld_pending = 1'b1; ld_rd = 5'd7;
    #1;
    check("haz_id_ready", id_ready, 0);
    tick();
    check("haz_drain_valid", ex_valid, 0);
    check("haz_ready_held", id_ready, 0);
    tick();
    tick();
    check("haz_ex_valid", ex_valid, 0);
    check("haz_stall_cnt", stall_cnt, 3);
    use_imm = 1'b1; imm = 32'h77;
    #1;
    check("haz_imm_ready", id_ready, 1);
    tick();
    check("haz_imm_valid", ex_valid, 1);
    check("haz_imm_src_b", src_b, 32'h77);
    check("haz_imm_cnt", stall_cnt, 3);
    ld_pending = 1'b0;

    // ---------------- back-pressure ----------------
    instr(5'd8, 32'h111, 32'h222, 3'd5, 5'd9);
    tick();
    check("bp_a_src_a", src_a, 32'h111);
    ex_ready = 1'b0;
    instr(5'd10, 32'h333, 32'h444, 3'd6, 5'd11);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_id_ready", id_ready, 0);
      tick();
      check("bp_ex_valid", ex_valid, 1);
      check("bp_src_a_frozen", src_a, 32'h111);
      check("bp_ctrl_frozen", alu_control, 3'd5);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", id_ready, 1);
    tick();
    check("bp_b_valid", ex_valid, 1);
    check("bp_b_src_a", src_a, 32'h333);
    check("bp_b_src_b", src_b, 32'h444);
    check("bp_b_rd", ex_rd, 5'd11);
    id_valid = 1'b0;
    tick();
    check("bp_no_dup", ex_valid, 0);

    // ---------------- flush ----------------
    instr(5'd12, 32'h555, 32'h0, 3'd1, 5'd13);
    flush = 1'b1;
    #1;
    check("fl_id_ready", id_ready, 1);
    tick();
    check("fl_ex_valid", ex_valid, 0);
    flush = 1'b0;
    instr(5'd14, 32'h666, 32'h0, 3'd2, 5'd15);
    tick();
    check("fl_next_valid", ex_valid, 1);
    check("fl_next_src_a", src_a, 32'h666);
    // A stall cycle that coincides with a flush still counts.
    rs1_addr = 5'd20; ld_pending = 1'b1; ld_rd = 5'd20; flush = 1'b1;
    tick();
    check("fl_stall_cnt", stall_cnt, 4);
    check("fl_stall_valid", ex_valid, 0);
    flush = 1'b0; ld_pending = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------
    instr(5'd3, 32'hDEAD, 32'hBEEF, 3'd4, 5'd5);
    tick();
    check("mid_pre_valid", ex_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ex_valid", ex_valid, 0);
    check("mid_src_a", src_a, 0);
    check("mid_src_b", src_b, 0);
    check("mid_alu_ctrl", alu_control, 0);
    check("mid_stall_cnt", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
